// File: rtl/cube_pkg.sv
// Shared definitions for the 8x8x8 light cube display path.
// Frame layout: row i occupies bits [8i+7:8i]; rows 8L..8L+7 form layer L,
// so one layer is the contiguous 64-bit slice [64L+63:64L].
package cube_pkg;

  localparam int CUBE_N  = 8;
  localparam int ROW_W   = 8;
  localparam int ROWS    = 64;
  localparam int FRAME_W = 512;
  localparam int LAYER_W = CUBE_N * ROW_W;

  // Scan FSM states, in the order a layer walks through them.
  typedef enum logic [1:0] {
    ST_SHIFT = 2'd0,
    ST_BLANK = 2'd1,
    ST_LATCH = 2'd2,
    ST_DWELL = 2'd3
  } scan_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/decoder3x8.sv
// Registered 3-to-8 one-hot decoder used for the layer drive.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous reset, active-low (output cleared)
//   load_i   in   update the output this cycle; otherwise it holds
//   en_i     in   1 = drive one-hot of idx_i, 0 = drive all zeros
//   idx_i    in   layer index 0..7
//   onehot_o out  registered one-hot (or zero) result
module decoder3x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [2:0] idx_i,
  output logic [7:0] onehot_o
);

  logic [7:0] onehot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_q <= 8'd0;
    end else if (load_i) begin
      onehot_q <= en_i ? (8'd1 << idx_i) : 8'd0;
    end
  end

  assign onehot_o = onehot_q;

endmodule

// File: rtl/cube_scan_driver.sv
// Display back-end for the 8x8x8 light cube. Double-buffers incoming frames
// and multiplexes one layer at a time: shift 64 column bits into the 74HC595
// chain, blank, latch, then light the layer. New frames only take effect at
// sweep boundaries so a sweep never mixes two frames.
// Ports:
//   clk             in   system clock
//   rst             in   asynchronous reset, active-low
//   frame_cube_flat in   512-bit frame, row i = bits [8i+7:8i]
//   frame_valid     in   capture frame_cube_flat this cycle (level)
//   ser_data        out  595 serial data
//   ser_clk         out  595 shift clock (data sampled on rising edge)
//   ser_latch       out  595 storage-register clock, high pulse
//   oe_n            out  595 output enable, active-low (1 = blanked)
//   layer_sel       out  one-hot layer drive, active-high
//   frame_done      out  1-cycle pulse at the end of each 8-layer sweep
// All outputs are registered; each reflects the FSM state of the previous
// cycle, so every output shares the same one-cycle offset.
module cube_scan_driver
  import cube_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int BLANK_CYCLES = 8,
  parameter int DWELL_CYCLES = 10000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_cube_flat,
  input  logic               frame_valid,
  output logic               ser_data,
  output logic               ser_clk,
  output logic               ser_latch,
  output logic               oe_n,
  output logic [7:0]         layer_sel,
  output logic               frame_done
);

  localparam int T_MAX = max3(CLK_DIV, BLANK_CYCLES, DWELL_CYCLES);
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] CD_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] BL_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DW_LAST = TW'(DWELL_CYCLES - 1);

  scan_state_e        state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               half_q, half_d;      // 0 = ser_clk low half, 1 = high half
  logic [5:0]         bit_q, bit_d;
  logic [2:0]         layer_q, layer_d;
  logic               first_q, first_d;    // first cycle after reset is a swap point
  logic [FRAME_W-1:0] active_q, active_d;
  logic [FRAME_W-1:0] pending_q, pending_d;
  logic               pend_valid_q, pend_valid_d;
  logic               ser_data_q, ser_data_d;
  logic               ser_clk_q, ser_clk_d;
  logic               ser_latch_q, ser_latch_d;
  logic               oe_n_q, oe_n_d;
  logic               frame_done_q, frame_done_d;
  logic               sweep_end;
  logic               swap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SHIFT;
      timer_q      <= '0;
      half_q       <= 1'b0;
      bit_q        <= 6'd63;
      layer_q      <= 3'd0;
      first_q      <= 1'b1;
      active_q     <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      ser_data_q   <= 1'b0;
      ser_clk_q    <= 1'b0;
      ser_latch_q  <= 1'b0;
      oe_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      layer_q      <= layer_d;
      first_q      <= first_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      ser_data_q   <= ser_data_d;
      ser_clk_q    <= ser_clk_d;
      ser_latch_q  <= ser_latch_d;
      oe_n_q       <= oe_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    half_d       = half_q;
    bit_d        = bit_q;
    layer_d      = layer_q;
    first_d      = 1'b0;
    active_d     = active_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    sweep_end    = 1'b0;

    case (state_q)
      ST_SHIFT: begin
        if (timer_q == CD_LAST) begin
          timer_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            bit_d  = bit_q - 6'd1;   // wraps 0 -> 63, ready for the next layer
            if (bit_q == 6'd0) state_d = ST_BLANK;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_BLANK: begin
        if (timer_q == BL_LAST) begin
          timer_d = '0;
          state_d = ST_LATCH;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_LATCH: begin
        if (timer_q == CD_LAST) begin
          timer_d = '0;
          state_d = ST_DWELL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DWELL: begin
        if (timer_q == DW_LAST) begin
          timer_d   = '0;
          state_d   = ST_SHIFT;
          layer_d   = layer_q + 3'd1;
          sweep_end = (layer_q == 3'd7);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_SHIFT;
    endcase

    swap = first_q | sweep_end;

    if (frame_valid) begin
      pending_d    = frame_cube_flat;
      pend_valid_d = 1'b1;
    end
    // A frame arriving on the swap cycle goes straight to the active buffer
    // and supersedes anything still pending.
    if (swap) begin
      if (frame_valid) begin
        active_d     = frame_cube_flat;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        active_d     = pending_q;
        pend_valid_d = 1'b0;
      end
    end

    // Data is taken from active_d so the very first bit after reset already
    // comes from the frame chosen on that swap cycle.
    ser_data_d   = (state_q == ST_SHIFT) ? active_d[{layer_q, bit_q}] : ser_data_q;
    ser_clk_d    = (state_q == ST_SHIFT) & half_q;
    ser_latch_d  = (state_q == ST_LATCH);
    frame_done_d = sweep_end;
    // During SHIFT the previously latched layer stays lit.
    case (state_q)
      ST_SHIFT: oe_n_d = oe_n_q;
      ST_DWELL: oe_n_d = 1'b0;
      default:  oe_n_d = 1'b1;
    endcase
  end

  decoder3x8 u_layer_dec (
    .clk      (clk),
    .rst_n    (rst),
    .load_i   (state_q != ST_SHIFT),
    .en_i     (state_q == ST_DWELL),
    .idx_i    (layer_q),
    .onehot_o (layer_sel)
  );

  assign ser_data   = ser_data_q;
  assign ser_clk    = ser_clk_q;
  assign ser_latch  = ser_latch_q;
  assign oe_n       = oe_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cube_scan_driver.sv
// Directed bench for cube_scan_driver with CLK_DIV=1, BLANK=2, DWELL=4
// (135 cycles per layer, 1080 per sweep). Cycle c counts rising edges after
// reset release, starting at 0; outputs are sampled on the falling edge that
// follows edge c.
module tb_cube_scan_driver;
  import cube_pkg::*;

  localparam int CD = 1;
  localparam int BL = 2;
  localparam int DW = 4;
  localparam int LP = 129 * CD + BL + DW;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [FRAME_W-1:0] flat = '0;
  logic               fv = 1'b0;
  logic               ser_data, ser_clk, ser_latch, oe_n, frame_done;
  logic [7:0]         layer_sel;

  cube_scan_driver #(.CLK_DIV(CD), .BLANK_CYCLES(BL), .DWELL_CYCLES(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_cube_flat (flat),
    .frame_valid     (fv),
    .ser_data        (ser_data),
    .ser_clk         (ser_clk),
    .ser_latch       (ser_latch),
    .oe_n            (oe_n),
    .layer_sel       (layer_sel),
    .frame_done      (frame_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected control outputs {ser_clk, ser_latch, oe_n, layer_sel, frame_done}
  // for cycle c, from the layer timeline.
  function automatic logic [11:0] exp_ctrl(input int c);
    int l, p;
    logic sc, lat, oen, fd;
    logic [7:0] ls;
    l = (c / LP) % 8;
    p = c % LP;
    sc = 1'b0; lat = 1'b0; oen = 1'b1; ls = 8'h00; fd = 1'b0;
    if (p < 128 * CD) begin
      sc = ((p / CD) % 2) == 1;
      if (c >= LP) begin
        oen = 1'b0;
        ls  = 8'd1 << ((l + 7) % 8);
      end
    end else if (p < 128 * CD + BL) begin
      oen = 1'b1;
    end else if (p < 129 * CD + BL) begin
      lat = 1'b1;
    end else begin
      oen = 1'b0;
      ls  = 8'd1 << l;
      fd  = (l == 7) && (p == LP - 1);
    end
    return {sc, lat, oen, ls, fd};
  endfunction

  function automatic logic [FRAME_W-1:0] lvl_frame(input int e);
    logic [FRAME_W-1:0] f;
    logic [31:0] ev;
    ev = 32'(e);
    for (int i = 0; i < 16; i++) f[32*i +: 32] = ev * 32'h0100_0193 + 32'(i) * 32'h9E37_79B9;
    return f;
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];

  task automatic push_frame(input logic [FRAME_W-1:0] fr, input int nl);
    for (int l = 0; l < nl; l++) exp_q.push_back(fr[64*l +: 64]);
  endtask

  int          cyc = -1;
  int          rises;
  logic [63:0] sr;
  logic        prev_clk, prev_latch, prev_data;

  always @(negedge clk) begin
    if (!rst) begin
      cyc = -1; rises = 0; sr = '0;
      prev_clk = 1'b0; prev_latch = 1'b0; prev_data = 1'b0;
    end else begin
      cyc++;
      check($sformatf("ctrl@%0d", cyc),
            64'({ser_clk, ser_latch, oe_n, layer_sel, frame_done}), 64'(exp_ctrl(cyc)));
      if (ser_clk && !prev_clk) begin
        check($sformatf("data_stable@%0d", cyc), 64'(ser_data), 64'(prev_data));
        sr = {sr[62:0], ser_data};
        rises++;
      end
      if (ser_latch && !prev_latch) begin
        check($sformatf("bits_per_layer@%0d", cyc), 64'(rises), 64'd64);
        rises = 0;
        check($sformatf("latch_expected@%0d", cyc), 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check($sformatf("layer_word@%0d", cyc), sr, exp_q.pop_front());
      end
      prev_clk = ser_clk; prev_latch = ser_latch; prev_data = ser_data;
    end
  end

  // ---------------- driver ----------------
  task automatic goto_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 20000) begin
      @(negedge clk); #1;
      guard++;
    end
    if (cyc != t) check($sformatf("reach_cyc_%0d", t), 64'(cyc), 64'(t));
  endtask

  logic [FRAME_W-1:0] fr_a, fr_b, fr_c, fr_0;

  initial begin
    fr_0 = '0; fr_0[0] = 1'b1;
    fr_b = '0; fr_b[511:504] = 8'hFF;
    for (int l = 0; l < 8; l++) begin
      fr_a[64*l +: 64] = 64'hA5A5_0000_0000_5A5A ^ 64'(l);
      fr_c[64*l +: 64] = 64'hC3C3_0F0F_0000_0000 | 64'(l << 4);
    end

    // sweep 0: only bit 0 set -> layer 0 word is 1, all others zero
    exp_q.push_back(64'h0000_0000_0000_0001);
    for (int l = 1; l < 8; l++) exp_q.push_back(64'h0);
    push_frame(fr_a, 8);               // sweep 1: A, untouched by B mid-sweep
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    exp_q.push_back(64'h0); exp_q.push_back(64'hFF00_0000_0000_0000); // sweep 2: B
    push_frame(fr_c, 8);               // sweep 3: C wins on the swap cycle
    push_frame(fr_c, 8);               // sweep 4: B was dropped
    push_frame(fr_c, 8);               // sweep 5
    push_frame(lvl_frame(6479), 8);    // sweeps 6..8: level-valid frames
    push_frame(lvl_frame(7559), 8);
    push_frame(lvl_frame(8499), 8);
    push_frame(lvl_frame(8499), 3);    // sweep 9 up to the mid-dwell reset
    for (int l = 0; l < 8; l++) exp_q.push_back(64'h0); // after reset: zero buffer

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 64'({ser_data, ser_clk, ser_latch, oe_n, layer_sel, frame_done}),
          64'({1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}));

    flat = fr_0; fv = 1'b1;
    #1 rst = 1'b1;
    goto_cyc(0);
    fv = 1'b0; flat = '0;
    check("ser_clk_cyc0", 64'(ser_clk), 64'd0);
    goto_cyc(1);
    check("ser_clk_cyc1", 64'(ser_clk), 64'd1);

    goto_cyc(499); flat = fr_a; fv = 1'b1;
    goto_cyc(500); fv = 1'b0; flat = '0;

    goto_cyc(1616); flat = fr_b; fv = 1'b1;
    goto_cyc(1617); fv = 1'b0; flat = '0;
    check("layer3_dwell", 64'(layer_sel), 64'h08);

    goto_cyc(2699); flat = fr_b; fv = 1'b1;
    goto_cyc(2700); fv = 1'b0; flat = '0;
    goto_cyc(3238); flat = fr_c; fv = 1'b1;
    goto_cyc(3239); fv = 1'b0; flat = '0;
    check("swap_frame_done", 64'(frame_done), 64'd1);

    goto_cyc(5499); fv = 1'b1; flat = lvl_frame(5500);
    for (int c = 5500; c < 8499; c++) begin
      goto_cyc(c);
      flat = lvl_frame(c + 1);
    end
    goto_cyc(8499); fv = 1'b0; flat = '0;

    goto_cyc(10122);
    check("pre_reset_layer", 64'(layer_sel), 64'h04);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", 64'({ser_data, ser_clk, ser_latch, oe_n, layer_sel, frame_done}),
          64'({1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0}));
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    goto_cyc(1085);
    check("all_latches_seen", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
